// File: rtl/a2d_pkg.sv
// Types, channel numbers and command encoding shared by the A2D round-robin
// scheduler and its gap timer.
package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GAP     = 3'd1,
      SEND_CH = 3'd2,
      WAIT_CH = 3'd3,
      SEND_RD = 3'd4,
      WAIT_RD = 3'd5
   } a2d_state_t;

   localparam logic [2:0] CH_LFT   = 3'd0;
   localparam logic [2:0] CH_RGHT  = 3'd4;
   localparam logic [2:0] CH_STEER = 3'd5;
   localparam logic [2:0] CH_BATT  = 3'd6;

   localparam int NUM_SLOTS = 4;
   localparam int RES_W     = 12;
   localparam int CMD_W     = 16;

   // Converter command: channel number in bits [13:11], everything else zero.
   function automatic logic [CMD_W-1:0] a2d_cmd(input logic [2:0] chnl);
      return {2'b00, chnl, 11'h000};
   endfunction

   function automatic logic [2:0] slot_chnl(input logic [1:0] slot);
      logic [2:0] chnl;
      case (slot)
         2'd0:    chnl = CH_LFT;
         2'd1:    chnl = CH_RGHT;
         2'd2:    chnl = CH_STEER;
         default: chnl = CH_BATT;
      endcase
      return chnl;
   endfunction

endpackage

// File: rtl/a2d_gap_tmr.sv
// Loadable down-counter that times the idle gap between conversion rounds.
// Counts down to zero and then holds there until loaded again.
module a2d_gap_tmr #(
   parameter int LOAD_VAL = 1023,
   parameter int CNT_W    = (LOAD_VAL < 1) ? 1 : $clog2(LOAD_VAL + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic ld,
   output logic zero
);

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOAD_VAL);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/a2d_round_robin.sv
// Round-robin scheduler for the shared SPI A2D: converts channels 0,4,5,6 in
// turn (two SPI transactions each) and holds the latest 12-bit result per channel.
module a2d_round_robin
   import a2d_pkg::*;
#(
   parameter int GAP_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              wrt,
   output logic [CMD_W-1:0]  cmd,
   input  logic              done,
   input  logic [CMD_W-1:0]  rd_data,
   output logic [RES_W-1:0]  lft_ld,
   output logic [RES_W-1:0]  rght_ld,
   output logic [RES_W-1:0]  steer_pot,
   output logic [RES_W-1:0]  batt,
   output logic              vld
);

   a2d_state_t       state_q;
   a2d_state_t       state_d;
   logic [1:0]       slot_q;
   logic [1:0]       slot_d;
   logic             wrt_q;
   logic             wrt_d;
   logic             vld_q;
   logic             vld_d;
   logic [CMD_W-1:0] cmd_q;
   logic [CMD_W-1:0] cmd_d;
   logic             cap;
   logic             gap_zero;
   logic [RES_W-1:0] res_q [NUM_SLOTS];
   logic             rd_data_unused;

   // The upper nibble of the converter response carries no result bits.
   assign rd_data_unused = ^rd_data[CMD_W-1:RES_W];

   // vld is high only in the first GAP cycle, so it doubles as the timer load.
   // Loading there rather than on the WAIT_RD exit puts the next round's first
   // wrt GAP_CYCLES+1 cycles after vld.
   a2d_gap_tmr #(
      .LOAD_VAL (GAP_CYCLES - 1)
   ) u_gap_tmr (
      .clk  (clk),
      .rst  (rst),
      .ld   (vld_q),
      .zero (gap_zero)
   );

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      cap     = 1'b0;
      vld_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = SEND_CH;
               slot_d  = 2'd0;
            end
         end
         GAP: begin
            if (!vld_q && gap_zero) begin
               state_d = en ? SEND_CH : IDLE;
            end
         end
         SEND_CH: state_d = WAIT_CH;
         WAIT_CH: begin
            // This response belongs to the previous command; only the handshake matters.
            if (done) begin
               state_d = SEND_RD;
            end
         end
         SEND_RD: state_d = WAIT_RD;
         WAIT_RD: begin
            if (done) begin
               cap = 1'b1;
               if (slot_q == 2'd3) begin
                  vld_d   = 1'b1;
                  slot_d  = 2'd0;
                  state_d = GAP;
               end else begin
                  slot_d  = slot_q + 2'd1;
                  state_d = SEND_CH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // SEND_CH/SEND_RD last exactly one cycle, so entering them is the wrt pulse.
   always_comb begin
      wrt_d = (state_d == SEND_CH) || (state_d == SEND_RD);
      cmd_d = cmd_q;
      if (state_d == SEND_CH) begin
         cmd_d = a2d_cmd(slot_chnl(slot_d));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         slot_q  <= 2'd0;
         wrt_q   <= 1'b0;
         vld_q   <= 1'b0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         wrt_q   <= wrt_d;
         vld_q   <= vld_d;
         cmd_q   <= cmd_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_res
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               res_q[gi] <= '0;
            end else if (cap && (slot_q == 2'(gi))) begin
               res_q[gi] <= rd_data[RES_W-1:0];
            end
         end
      end
   endgenerate

   assign wrt       = wrt_q;
   assign vld       = vld_q;
   assign cmd       = cmd_q;
   assign lft_ld    = res_q[0];
   assign rght_ld   = res_q[1];
   assign steer_pot = res_q[2];
   assign batt      = res_q[3];

endmodule

// File: tb/tb_a2d_round_robin.sv
// Bench for a2d_round_robin: two instances (gap 16 and gap 1) driven by an SPI
// responder and checked every cycle against a transaction-level schedule model.
module tb_a2d_round_robin;

   localparam int N     = 2;
   localparam int GAP_A = 16;
   localparam int GAP_B = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_w      [N];
   logic        done_w    [N];
   logic        wrt_w     [N];
   logic        vld_w     [N];
   logic [15:0] rd_data_w [N];
   logic [15:0] cmd_w     [N];
   logic [11:0] lft_w     [N];
   logic [11:0] rght_w    [N];
   logic [11:0] steer_w   [N];
   logic [11:0] batt_w    [N];

   always #10 clk = ~clk;

   a2d_round_robin #(.GAP_CYCLES(GAP_A)) dut_a (
      .clk(clk), .rst(rst), .en(en_w[0]), .wrt(wrt_w[0]), .cmd(cmd_w[0]),
      .done(done_w[0]), .rd_data(rd_data_w[0]), .lft_ld(lft_w[0]), .rght_ld(rght_w[0]),
      .steer_pot(steer_w[0]), .batt(batt_w[0]), .vld(vld_w[0])
   );

   a2d_round_robin #(.GAP_CYCLES(GAP_B)) dut_b (
      .clk(clk), .rst(rst), .en(en_w[1]), .wrt(wrt_w[1]), .cmd(cmd_w[1]),
      .done(done_w[1]), .rd_data(rd_data_w[1]), .lft_ld(lft_w[1]), .rght_ld(rght_w[1]),
      .steer_pot(steer_w[1]), .batt(batt_w[1]), .vld(vld_w[1])
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Schedule model: mode 0 idle, 1 running a round, 2 in the inter-round gap.
   int          mode     [N] = '{0, 0};
   int          k_cnt    [N] = '{0, 0};
   int          exp_wrt  [N] = '{-1, -1};
   int          exp_vld  [N] = '{-1, -1};
   int          gap_end  [N] = '{-1, -1};
   logic [11:0] exp_res  [N][4];
   bit          out_act  [N] = '{0, 0};
   int          out_wrt  [N] = '{0, 0};
   int          done_at  [N] = '{0, 0};
   logic [15:0] out_data [N];

   int          wrt_cnt    [N] = '{0, 0};
   int          vld_cnt    [N] = '{0, 0};
   int          last_vld   [N] = '{-1, -1};
   int          last_wrt   [N] = '{-1, -1};
   int          vld_period [N] = '{0, 0};
   logic [15:0] cmd_log [$];

   int          lat_fix  [N] = '{40, 2};
   bit          use_tab  [N] = '{0, 0};
   bit          rnd_spur [N] = '{0, 0};
   int          spur_req [N] = '{0, 0};
   int          spur_srv [N] = '{0, 0};
   logic [15:0] spur_dat [N] = '{16'h0FFF, 16'h0FFF};

   logic [15:0] tab     [4] = '{16'hF123, 16'h0456, 16'h0789, 16'h0ABC};
   logic [15:0] cmd_seq [8] = '{16'h0000, 16'h0000, 16'h2000, 16'h2000,
                                16'h2800, 16'h2800, 16'h3000, 16'h3000};
   string       rn      [4] = '{"lft_ld", "rght_ld", "steer_pot", "batt"};

   task automatic check(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", i, nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] exp_cmd(input int slot);
      case (slot)
         0:       return 16'h0000;
         1:       return 16'h2000;
         2:       return 16'h2800;
         default: return 16'h3000;
      endcase
   endfunction

   function automatic int gap_of(input int i);
      return (i == 0) ? GAP_A : GAP_B;
   endfunction

   task automatic step(input int i);
      logic [11:0] act_res [4];
      logic        dn;
      logic [15:0] dat;
      act_res[0] = lft_w[i];
      act_res[1] = rght_w[i];
      act_res[2] = steer_w[i];
      act_res[3] = batt_w[i];
      if (rst) begin
         mode[i] = 0; k_cnt[i] = 0; out_act[i] = 0; exp_wrt[i] = -1; exp_vld[i] = -1;
         for (int s = 0; s < 4; s++) exp_res[i][s] = 12'h000;
         check(i, "rst_wrt", wrt_w[i], 0);
         check(i, "rst_vld", vld_w[i], 0);
         check(i, "rst_cmd", cmd_w[i], 0);
         for (int s = 0; s < 4; s++) check(i, rn[s], act_res[s], 0);
         done_w[i] = 1'b0;
         rd_data_w[i] = 16'h0000;
         return;
      end
      check(i, "wrt", wrt_w[i], 32'(cyc == exp_wrt[i]));
      check(i, "vld", vld_w[i], 32'(cyc == exp_vld[i]));
      for (int s = 0; s < 4; s++) check(i, rn[s], act_res[s], exp_res[i][s]);
      if (out_act[i]) check(i, "cmd_hold", cmd_w[i], exp_cmd(k_cnt[i] >> 1));
      if (wrt_w[i]) begin
         check(i, "wrt_cmd", cmd_w[i], exp_cmd(k_cnt[i] >> 1));
         wrt_cnt[i]++;
         last_wrt[i] = cyc;
         if (i == 0) cmd_log.push_back(cmd_w[0]);
         out_act[i] = 1'b1;
         out_wrt[i] = cyc;
         done_at[i] = cyc + ((lat_fix[i] != 0) ? lat_fix[i] : int'($urandom_range(1, 8)));
         out_data[i] = (use_tab[i] && k_cnt[i][0]) ? tab[k_cnt[i] >> 1] : 16'($urandom);
      end
      if (vld_w[i]) begin
         vld_cnt[i]++;
         if (last_vld[i] >= 0) vld_period[i] = cyc - last_vld[i];
         last_vld[i] = cyc;
         $display("dut%0d round %0d @%0d: lft=%h rght=%h steer=%h batt=%h", i, vld_cnt[i], cyc,
                  lft_w[i], rght_w[i], steer_w[i], batt_w[i]);
      end
      dn  = 1'b0;
      dat = 16'($urandom);
      if (out_act[i] && cyc == done_at[i]) begin
         dn = 1'b1; dat = out_data[i];
      end else if (spur_req[i] != spur_srv[i]) begin
         dn = 1'b1; dat = spur_dat[i]; spur_srv[i]++;
      end else if (rnd_spur[i] && (!out_act[i] || out_wrt[i] == cyc) && $urandom_range(0, 15) == 0) begin
         dn = 1'b1;
      end
      done_w[i]    = dn;
      rd_data_w[i] = dat;
      if (dn && out_act[i] && cyc > out_wrt[i]) begin
         if (k_cnt[i][0]) exp_res[i][k_cnt[i] >> 1] = dat[11:0];
         k_cnt[i]++;
         out_act[i] = 1'b0;
         if (k_cnt[i] < 8) begin
            exp_wrt[i] = cyc + 1;
         end else begin
            k_cnt[i]   = 0;
            exp_vld[i] = cyc + 1;
            gap_end[i] = cyc + 1 + gap_of(i);
            mode[i]    = 2;
         end
      end else if (mode[i] == 0) begin
         if (en_w[i]) begin exp_wrt[i] = cyc + 1; mode[i] = 1; end
      end else if (mode[i] == 2 && cyc == gap_end[i]) begin
         if (en_w[i]) begin exp_wrt[i] = cyc + 1; mode[i] = 1; end
         else mode[i] = 0;
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) step(i);
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_vld(input int i, input int tgt, input int lim);
      int c = 0;
      while (vld_cnt[i] < tgt && c < lim) begin @(posedge clk); #1; c++; end
      check(i, "vld_reached", 32'(vld_cnt[i] >= tgt), 1);
   endtask

   task automatic wait_wrt(input int i, input int tgt, input int lim);
      int c = 0;
      while (wrt_cnt[i] < tgt && c < lim) begin @(posedge clk); #1; c++; end
      check(i, "wrt_reached", 32'(wrt_cnt[i] >= tgt), 1);
   endtask

   task automatic seq_a();
      wait_cycles(8);
      spur_req[0]++;
      wait_cycles(8);
      check(0, "idle_no_wrt", wrt_cnt[0], 0);
      use_tab[0] = 1'b1;
      en_w[0] = 1'b1;
      wait_vld(0, 1, 1000);
      use_tab[0] = 1'b0;
      check(0, "round_lft", lft_w[0], 12'h123);
      check(0, "round_rght", rght_w[0], 12'h456);
      check(0, "round_steer", steer_w[0], 12'h789);
      check(0, "round_batt", batt_w[0], 12'hABC);
      check(0, "cmd_log_len", cmd_log.size(), 8);
      for (int j = 0; j < 8 && j < cmd_log.size(); j++) check(0, "cmd_seq", cmd_log[j], cmd_seq[j]);
      wait_cycles(4);
      spur_dat[0] = 16'h0FFF;
      spur_req[0]++;
      wait_wrt(0, 9, 100);
      check(0, "gap_len", last_wrt[0] - last_vld[0], 17);
      check(0, "one_vld", vld_cnt[0], 1);
      wait_cycles(5);
      spur_req[0]++;
      wait_cycles(3);
      check(0, "wait_ch_spur_lft", lft_w[0], 12'h123);
      check(0, "wait_ch_advance", wrt_cnt[0], 10);
      wait_wrt(0, 11, 200);
      en_w[0] = 1'b0;
      wait_vld(0, 2, 1000);
      wait_cycles(60);
      check(0, "drop_no_wrt", wrt_cnt[0], 16);
      check(0, "drop_vld_cnt", vld_cnt[0], 2);
      en_w[0] = 1'b1;
      wait_wrt(0, 18, 400);
      wait_cycles(10);
      rst = 1'b1;
      #1;
      check(0, "rst_now_lft", lft_w[0], 0);
      check(0, "rst_now_batt", batt_w[0], 0);
      check(0, "rst_now_cmd", cmd_w[0], 0);
      check(0, "rst_now_wrt", wrt_w[0], 0);
      en_w[0] = 1'b0;
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(20);
      check(0, "rst_no_wrt", wrt_cnt[0], 18);
   endtask

   task automatic seq_b();
      en_w[1] = 1'b1;
      wait_vld(1, 1, 500);
      for (int r = 0; r < 6; r++) begin
         wait_vld(1, r + 2, 100);
         check(1, "vld_period", vld_period[1], 26);
      end
   endtask

   initial begin
      rst = 1'b1;
      en_w[0] = 1'b0; en_w[1] = 1'b0;
      done_w[0] = 1'b0; done_w[1] = 1'b0;
      rd_data_w[0] = 16'h0; rd_data_w[1] = 16'h0;
      for (int i = 0; i < N; i++)
         for (int s = 0; s < 4; s++) exp_res[i][s] = 12'h000;
      wait_cycles(3);
      check(0, "init_lft", lft_w[0], 0);
      check(0, "init_cmd", cmd_w[0], 0);
      check(0, "init_wrt", wrt_w[0], 0);
      check(1, "init_vld", vld_w[1], 0);
      rst = 1'b0;
      fork
         seq_a();
         seq_b();
      join
      lat_fix[0] = 0; lat_fix[1] = 0;
      rnd_spur[0] = 1'b1; rnd_spur[1] = 1'b1;
      for (int it = 0; it < 40; it++) begin
         wait_cycles($urandom_range(20, 200));
         en_w[0] = ($urandom_range(0, 3) != 0);
         en_w[1] = ($urandom_range(0, 3) != 0);
      end
      en_w[0] = 1'b1; en_w[1] = 1'b1;
      wait_cycles(300);
      check(0, "random_rounds", 32'(vld_cnt[0] > 3), 1);
      check(1, "random_rounds", 32'(vld_cnt[1] > 10), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
